// File: rtl/scale_pkg.sv
// Shared types and constants for the scale-down configuration controller.
package scale_pkg;

    localparam int K_FRAC_BITS = 8;
    localparam int K_W         = 16;
    localparam int DIM_W       = 12;
    localparam logic [K_W-1:0] K_SAT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DIV_H = 3'd1,
        ST_DIV_V = 3'd2,
        ST_PEND  = 3'd3,
        ST_APPLY = 3'd4
    } state_e;

    // Elaboration-time Q8.8 factor, used for the reset values of the k outputs.
    function automatic logic [K_W-1:0] k_calc(input int unsigned s, input int unsigned t);
        int unsigned q;
        if (t == 0) return K_SAT;
        q = (s << K_FRAC_BITS) / t;
        if (q > 32'(K_SAT)) return K_SAT;
        return K_W'(q);
    endfunction

endpackage

// File: rtl/scale_div_seq.sv
// Sequential restoring divider: k = floor({dividend, 8'b0} / divisor).
// Start loads the operands, then one quotient bit is produced per cycle.
// done_o pulses for one cycle once all bits are in; k_o is valid while done_o is high.
// Quotients wider than 16 bits, or a zero divisor, saturate to K_SAT.
module scale_div_seq
    import scale_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [DIM_W-1:0] dividend_i,
    input  logic [DIM_W-1:0] divisor_i,
    output logic             done_o,
    output logic [K_W-1:0]   k_o
);

    localparam int NUM_W = DIM_W + K_FRAC_BITS;
    localparam logic [4:0] ITERS = 5'(NUM_W);

    logic [NUM_W-1:0] quo_q;
    logic [DIM_W-1:0] rem_q;
    logic [DIM_W-1:0] divisor_q;
    logic [4:0]       cnt_q;
    logic             done_q;

    logic [DIM_W:0]   rem_sh;
    logic [DIM_W-1:0] rem_sub;
    logic             ge;

    // Trial subtraction for the current quotient bit.
    // NOTE: always_comb uses blocking assignments and always_ff uses non-blocking; mixing them
    // in clocked logic creates order-dependent simulation that need not match the netlist.
    always_comb begin
        rem_sh  = {rem_q, quo_q[NUM_W-1]};
        ge      = (rem_sh >= {1'b0, divisor_q});
        // When ge holds the true difference is below the divisor, so the low bits are exact.
        rem_sub = rem_sh[DIM_W-1:0] - divisor_q;
    end

    // Load on start, then shift one quotient bit in per cycle until the counter drains.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            quo_q     <= '0;
            rem_q     <= '0;
            divisor_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else if (start_i) begin
            quo_q     <= {dividend_i, K_FRAC_BITS'(0)};
            rem_q     <= '0;
            divisor_q <= divisor_i;
            cnt_q     <= ITERS;
            done_q    <= 1'b0;
        end else if (cnt_q != 5'd0) begin
            quo_q  <= {quo_q[NUM_W-2:0], ge};
            rem_q  <= ge ? rem_sub : rem_sh[DIM_W-1:0];
            cnt_q  <= cnt_q - 5'd1;
            done_q <= (cnt_q == 5'd1);
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done_o = done_q;
    assign k_o    = ((divisor_q == '0) || (|quo_q[NUM_W-1:K_W])) ? K_SAT : quo_q[K_W-1:0];

endmodule

// File: rtl/scale_cfg_ctrl.sv
// Frame-synchronous configuration controller for the scale-down path.
// A host request is captured, both Q8.8 factors are computed on one shared divider
// (horizontal then vertical, 42 cycles from accept to PEND), and all six values are
// applied to the scaler together on the first synchronised frame start seen in PEND.
// Optional macro SCALE_CFG_CHECK_EN: reject zero or upscaling targets and flag cfg_err.
module scale_cfg_ctrl
    import scale_pkg::*;
#(
    parameter int DEF_SW = 1920,
    parameter int DEF_SH = 1080,
    parameter int DEF_TW = 1280,
    parameter int DEF_TH = 720,
    parameter bit VS_POL = 1'b1
) (
    input  logic             sram_clk,
    input  logic             sys_rst_n,
    input  logic             vs,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIM_W-1:0] cfg_sw,
    input  logic [DIM_W-1:0] cfg_sh,
    input  logic [DIM_W-1:0] cfg_tw,
    input  logic [DIM_W-1:0] cfg_th,
    output logic [DIM_W-1:0] s_width,
    output logic [DIM_W-1:0] s_height,
    output logic [DIM_W-1:0] t_width,
    output logic [DIM_W-1:0] t_height,
    output logic [K_W-1:0]   h_scale_k,
    output logic [K_W-1:0]   v_scale_k,
    output logic             cfg_busy,
    output logic             cfg_applied,
    output logic             cfg_err
);

    localparam logic [DIM_W-1:0] RST_SW = DIM_W'(DEF_SW);
    localparam logic [DIM_W-1:0] RST_SH = DIM_W'(DEF_SH);
    localparam logic [DIM_W-1:0] RST_TW = DIM_W'(DEF_TW);
    localparam logic [DIM_W-1:0] RST_TH = DIM_W'(DEF_TH);
    localparam logic [K_W-1:0]   RST_HK = k_calc(DEF_SW, DEF_TW);
    localparam logic [K_W-1:0]   RST_VK = k_calc(DEF_SH, DEF_TH);

    state_e state_q, state_d;

    logic             vs_s1, vs_s2, vs_s3;
    logic             fs_edge;
    logic             req_bad;
    logic             div_start, div_done;
    logic [DIM_W-1:0] div_a, div_b;
    logic [K_W-1:0]   div_k;

    logic [DIM_W-1:0] pend_sw_q, pend_sh_q, pend_tw_q, pend_th_q;
    logic [K_W-1:0]   pend_hk_q, pend_vk_q;
    logic [DIM_W-1:0] s_width_q, s_height_q, t_width_q, t_height_q;
    logic [K_W-1:0]   h_k_q, v_k_q;

    // Synchronise vs; the third flop holds the previous synchronised level for edge detection.
    always_ff @(posedge sram_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            {vs_s3, vs_s2, vs_s1} <= {3{~VS_POL}};
        end else begin
            {vs_s3, vs_s2, vs_s1} <= {vs_s2, vs_s1, vs};
        end
    end

    assign fs_edge = (vs_s2 == VS_POL) && (vs_s3 != VS_POL);

`ifdef SCALE_CFG_CHECK_EN
    logic err_q;

    assign req_bad = (cfg_tw == '0) || (cfg_th == '0) || (cfg_tw > cfg_sw) || (cfg_th > cfg_sh);

    // Sticky error: updated only by a transfer, set on a rejected one and cleared by a good one.
    always_ff @(posedge sram_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_q <= 1'b0;
        end else if (cfg_ready && cfg_valid) begin
            err_q <= req_bad;
        end
    end

    assign cfg_err = err_q;
`else
    assign req_bad = 1'b0;
    assign cfg_err = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge sram_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and divider control; the H divide starts on the accept edge straight from the
    // request inputs, the V divide starts on the H done cycle from the pending registers.
    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d   = state_q;
        div_start = 1'b0;
        div_a     = cfg_sw;
        div_b     = cfg_tw;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_valid && !req_bad) begin
                    div_start = 1'b1;
                    state_d   = ST_DIV_H;
                end
            end
            ST_DIV_H: begin
                div_a = pend_sh_q;
                div_b = pend_th_q;
                if (div_done) begin
                    div_start = 1'b1;
                    state_d   = ST_DIV_V;
                end
            end
            ST_DIV_V: begin
                if (div_done) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (fs_edge) state_d = ST_APPLY;
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    scale_div_seq u_div (
        .clk_i      (sram_clk),
        .rst_ni     (sys_rst_n),
        .start_i    (div_start),
        .dividend_i (div_a),
        .divisor_i  (div_b),
        .done_o     (div_done),
        .k_o        (div_k)
    );

    // Pending request and computed factors; a request is only captured from IDLE.
    always_ff @(posedge sram_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pend_sw_q <= '0;
            pend_sh_q <= '0;
            pend_tw_q <= '0;
            pend_th_q <= '0;
            pend_hk_q <= '0;
            pend_vk_q <= '0;
        end else begin
            if (state_q == ST_IDLE && cfg_valid && !req_bad) begin
                pend_sw_q <= cfg_sw;
                pend_sh_q <= cfg_sh;
                pend_tw_q <= cfg_tw;
                pend_th_q <= cfg_th;
            end
            if (state_q == ST_DIV_H && div_done) pend_hk_q <= div_k;
            if (state_q == ST_DIV_V && div_done) pend_vk_q <= div_k;
        end
    end

    // Active outputs: all six change together on the edge into APPLY, otherwise only on reset.
    always_ff @(posedge sram_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s_width_q  <= RST_SW;
            s_height_q <= RST_SH;
            t_width_q  <= RST_TW;
            t_height_q <= RST_TH;
            h_k_q      <= RST_HK;
            v_k_q      <= RST_VK;
        end else if (state_q == ST_PEND && fs_edge) begin
            s_width_q  <= pend_sw_q;
            s_height_q <= pend_sh_q;
            t_width_q  <= pend_tw_q;
            t_height_q <= pend_th_q;
            h_k_q      <= pend_hk_q;
            v_k_q      <= pend_vk_q;
        end
    end

    assign s_width     = s_width_q;
    assign s_height    = s_height_q;
    assign t_width     = t_width_q;
    assign t_height    = t_height_q;
    assign h_scale_k   = h_k_q;
    assign v_scale_k   = v_k_q;
    assign cfg_ready   = (state_q == ST_IDLE);
    assign cfg_busy    = (state_q == ST_DIV_H) || (state_q == ST_DIV_V) || (state_q == ST_PEND);
    assign cfg_applied = (state_q == ST_APPLY);

endmodule
